attn_pair_tx: RTL

ATTN_PAIR_TX -- requirements
Module: attn_pair_tx

---
 rtl/attn_pair_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/attn_pair_tx.sv
// attn_pair_tx: buffers one row of query/key features, then streams them as interleaved q/k pairs.
// Latency: the first byte is offered the cycle after the last load byte. One byte per cycle while tx_rdy=1.
// Backpressure: tx_rdy=0 holds the current byte and state. ld_rdy is low for the whole send and done phase.
//
// Ports:
//   clk, rst_n        rising-edge clock; synchronous active-low reset
//   ld_vld/ld_rdy     load handshake; ld_data is the row byte (q[0..NFEAT-1] then k[0..NFEAT-1])
//   tx_vld/tx_rdy     transmit handshake; tx_data sequence is q0,k0,q1,k1,...
//   busy              high in any state other than IDLE
//   done              one-cycle pulse after the last pair has been sent
//   mac_exp           Q2.14 running sum of q[i]*k[i] over the sent pairs, wraps modulo 2^17
module attn_pair_tx #(
  parameter int NFEAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ld_vld,
  output logic        ld_rdy,
  input  logic [7:0]  ld_data,
  output logic        tx_vld,
  input  logic        tx_rdy,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic        done,
  output logic [16:0] mac_exp
);

  localparam int NBYTE = 2 * NFEAT;
  localparam int CW    = $clog2(NBYTE);
  localparam int IW    = $clog2(NFEAT);

  localparam logic [CW-1:0] LAST_LD = CW'(NBYTE - 1);
  localparam logic [IW-1:0] LAST_I  = IW'(NFEAT - 1);
  localparam logic [CW-1:0] K_BASE  = CW'(NFEAT);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_LOAD   = 3'd1;
  localparam logic [2:0] ST_SEND_Q = 3'd2;
  localparam logic [2:0] ST_SEND_K = 3'd3;
  localparam logic [2:0] ST_DONE   = 3'd4;

  logic [2:0]      state;
  logic [2:0]      state_nxt;
  logic [CW-1:0]   ld_cnt;
  logic [IW-1:0]   idx;
  logic [7:0]      row_buf [NBYTE];

  logic            ld_fire;
  logic            tx_fire;
  logic            ld_last;
  logic            pair_last;
  logic [CW-1:0]   q_sel;
  logic [CW-1:0]   k_sel;
  logic [7:0]      q_cur;
  logic [7:0]      k_cur;
  logic signed [15:0] prod;
  logic [16:0]     prod_ext;

  // Handshake qualifiers. Everything below is a function of registered
  // state, so tx_vld/tx_data never depend combinationally on tx_rdy.
  assign ld_rdy  = (state == ST_IDLE) || (state == ST_LOAD);
  assign tx_vld  = (state == ST_SEND_Q) || (state == ST_SEND_K);
  assign busy    = (state != ST_IDLE);
  assign done    = (state == ST_DONE);

  assign ld_fire   = ld_vld && ld_rdy;
  assign tx_fire   = tx_vld && tx_rdy;
  assign ld_last   = (ld_cnt == LAST_LD);
  assign pair_last = (idx == LAST_I);

  // q[i] lives at row_buf[i], k[i] at row_buf[NFEAT+i].
  assign q_sel = CW'(idx);
  assign k_sel = K_BASE + CW'(idx);
  assign q_cur = row_buf[q_sel];
  assign k_cur = row_buf[k_sel];

  always_comb begin
    tx_data = 8'h00;
    case (state)
      ST_SEND_Q: tx_data = q_cur;
      ST_SEND_K: tx_data = k_cur;
      default:   tx_data = 8'h00;
    endcase
  end

  // Full signed 8x8 product, sign-extended to the accumulator width.
  assign prod     = $signed(q_cur) * $signed(k_cur);
  assign prod_ext = {prod[15], prod};

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (ld_fire) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        if (ld_fire && ld_last) state_nxt = ST_SEND_Q;
      end
      ST_SEND_Q: begin
        if (tx_fire) state_nxt = ST_SEND_K;
      end
      ST_SEND_K: begin
        if (tx_fire) state_nxt = pair_last ? ST_DONE : ST_SEND_Q;
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      ld_cnt  <= '0;
      idx     <= '0;
      mac_exp <= '0;
      for (int n = 0; n < NBYTE; n++) begin
        row_buf[n] <= 8'h00;
      end
    end else begin
      state <= state_nxt;

      // ld_cnt is 0 whenever IDLE is entered, so the first byte of a row
      // always lands in q[0]. The load only completes from LOAD since a row
      // holds at least four bytes.
      if (ld_fire) begin
        row_buf[ld_cnt] <= ld_data;
        ld_cnt          <= ld_last ? '0 : ld_cnt + 1'b1;
      end

      // Start of a transmission: restart the pair index and the expected sum.
      if ((state == ST_LOAD) && ld_fire && ld_last) begin
        idx     <= '0;
        mac_exp <= '0;
      end

      // Accumulate when the key byte of pair i is accepted.
      if ((state == ST_SEND_K) && tx_fire) begin
        mac_exp <= mac_exp + prod_ext;
        idx     <= pair_last ? '0 : idx + 1'b1;
      end
    end
  end

endmodule
